// File: rtl/ov7670_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_pkg
// Shared types and constants for the OV7670 capture path.
//   cap_state_t      : capture FSM states
//   RGB565_W         : width of one packed RGB565 pixel
//   FRAME_W_DEFAULT  : default pixels per line (VGA)
//   FRAME_H_DEFAULT  : default lines per frame (VGA)
//   CNT_W_DEFAULT    : default pixel/line counter width
// ----------------------------------------------------------------------------
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VS  = 3'd1,
    WAIT_FRM = 3'd2,
    ACTIVE   = 3'd3,
    DROP     = 3'd4
  } cap_state_t;

  localparam int RGB565_W        = 16;
  localparam int FRAME_W_DEFAULT = 640;
  localparam int FRAME_H_DEFAULT = 480;
  localparam int CNT_W_DEFAULT   = 10;

endpackage

// File: rtl/ov7670_cam_sample.sv
// ----------------------------------------------------------------------------
// ov7670_cam_sample
// Registers the raw OV7670 pins once in the PCLK domain and derives edge
// strobes from the registered value and its previous value.
// Ports:
//   clk_write  : camera PCLK
//   rst_n      : asynchronous active-low reset
//   cam_vsync  : raw VSYNC pin
//   cam_href   : raw HREF pin
//   cam_data   : raw D[7:0] pins
//   vs_q/hr_q  : registered VSYNC/HREF
//   d_q        : registered data byte
//   vs_rise    : vs_q went 0->1 (start of vertical blanking)
//   vs_fall    : vs_q went 1->0 (start of active frame)
//   hr_fall    : hr_q went 1->0 (end of a line)
// ----------------------------------------------------------------------------
module ov7670_cam_sample (
  input  logic       clk_write,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vs_q,
  output logic       hr_q,
  output logic [7:0] d_q,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       hr_fall
);

  logic vs_prev;
  logic hr_prev;

  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      d_q     <= 8'h00;
      vs_prev <= 1'b0;
      hr_prev <= 1'b0;
    end else begin
      vs_q    <= cam_vsync;
      hr_q    <= cam_href;
      d_q     <= cam_data;
      vs_prev <= vs_q;
      hr_prev <= hr_q;
    end
  end

  assign vs_rise = vs_q & ~vs_prev;
  assign vs_fall = ~vs_q & vs_prev;
  assign hr_fall = ~hr_q & hr_prev;

endmodule

// File: rtl/ov7670_capture_writer.sv
// ----------------------------------------------------------------------------
// ov7670_capture_writer
// Producer side of the camera-to-frame-buffer FIFO. Samples the OV7670 bus in
// the PCLK domain, packs byte pairs into RGB565 pixels, writes them into the
// FIFO while respecting fifo_full, and reports frame completion, overflow and
// frame-geometry errors.
//
// Optional build macro: OV7670_TEST_PATTERN_EN
//   When defined, adds input test_pattern; while it is high the written pixel
//   is {line_count[7:0], pixel_cnt[7:0]} instead of camera data (requires
//   CNT_W >= 8). Write timing is still driven by HREF byte pairs.
//
// Ports:
//   clk_write    : camera PCLK, rising edge
//   rst_n        : asynchronous active-low reset (shared with the FIFO)
//   capture_en   : 1 = capture frames continuously
//   cam_vsync    : OV7670 VSYNC (high = vertical blanking)
//   cam_href     : OV7670 HREF (high = valid line bytes)
//   cam_data     : OV7670 D[7:0]
//   test_pattern : (macro only) substitute counter pattern for pixel data
//   fifo_full    : FIFO full flag, write-domain synchronous
//   fifo_write   : one-cycle write strobe
//   fifo_data    : pixel {hi_byte, lo_byte}
//   frame_done   : one-cycle pulse at end of each captured frame
//   overflow     : sticky, a pixel met fifo_full
//   size_err     : sticky, a completed frame/line had the wrong geometry
//   line_count   : lines completed in the current frame
// ----------------------------------------------------------------------------
module ov7670_capture_writer
  import ov7670_pkg::*;
#(
  parameter int DATA_WIDTH = RGB565_W,
  parameter int FRAME_W    = FRAME_W_DEFAULT,
  parameter int FRAME_H    = FRAME_H_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clk_write,
  input  logic                  rst_n,
  input  logic                  capture_en,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
`ifdef OV7670_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  size_err,
  output logic [CNT_W-1:0]      line_count
);

  // Sampled camera bus
  logic       vs_q;
  logic       hr_q;
  logic [7:0] d_q;
  logic       vs_rise;
  logic       vs_fall;
  logic       hr_fall;

  ov7670_cam_sample u_sample (
    .clk_write (clk_write),
    .rst_n     (rst_n),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .vs_q      (vs_q),
    .hr_q      (hr_q),
    .d_q       (d_q),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .hr_fall   (hr_fall)
  );

  cap_state_t state;
  cap_state_t state_next;

  logic             phase;
  logic [7:0]       hi_byte;
  logic [CNT_W-1:0] pixel_cnt;
  // Set on leaving IDLE; lets the first ACTIVE entry clear the sticky flags
  // while back-to-back frames keep them.
  logic             fresh;

  // Control strobes decoded by the FSM for the datapath
  logic enter_active;
  logic take_hi;
  logic emit_pixel;
  logic pixel_blocked;
  logic line_end;
  logic frame_end;

  logic [CNT_W-1:0]      pixel_cnt_inc;
  logic [CNT_W-1:0]      line_count_inc;
  logic [CNT_W-1:0]      line_count_end;
  logic                  line_bad;
  logic                  frame_bad;
  logic [DATA_WIDTH-1:0] pixel;

  // Counters saturate rather than wrap so an over-long line or frame can
  // never alias back onto the expected geometry.
  assign pixel_cnt_inc  = (pixel_cnt == '1) ? pixel_cnt : pixel_cnt + CNT_W'(1);
  assign line_count_inc = (line_count == '1) ? line_count : line_count + CNT_W'(1);
  assign line_count_end = line_end ? line_count_inc : line_count;

  // A line is bad if it held the wrong number of pixels or left a dangling
  // high byte; a frame is bad if its line total (including a line closed by
  // the frame end itself) is off.
  assign line_bad  = line_end && ((pixel_cnt != CNT_W'(FRAME_W)) || phase);
  assign frame_bad = frame_end && (line_count_end != CNT_W'(FRAME_H));

  always_comb begin
    pixel = DATA_WIDTH'({hi_byte, d_q});
`ifdef OV7670_TEST_PATTERN_EN
    if (test_pattern) begin
      pixel = DATA_WIDTH'({line_count[7:0], pixel_cnt[7:0]});
    end
`endif
  end

  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode. In ACTIVE a frame end takes priority over
  // a line end, which takes priority over byte capture; bytes presented on
  // the frame-end or line-end cycle are not part of any pixel.
  always_comb begin
    state_next    = state;
    enter_active  = 1'b0;
    take_hi       = 1'b0;
    emit_pixel    = 1'b0;
    pixel_blocked = 1'b0;
    line_end      = 1'b0;
    frame_end     = 1'b0;

    case (state)
      IDLE: begin
        if (capture_en) begin
          state_next = WAIT_VS;
        end
      end

      WAIT_VS: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vs_q) begin
          state_next = WAIT_FRM;
        end
      end

      WAIT_FRM: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vs_fall) begin
          state_next   = ACTIVE;
          enter_active = 1'b1;
        end
      end

      ACTIVE: begin
        if (vs_rise) begin
          frame_end  = 1'b1;
          line_end   = hr_q | hr_fall;
          state_next = capture_en ? WAIT_FRM : IDLE;
        end else if (hr_fall) begin
          line_end = 1'b1;
        end else if (hr_q) begin
          if (!phase) begin
            take_hi = 1'b1;
          end else if (fifo_full) begin
            pixel_blocked = 1'b1;
            state_next    = DROP;
          end else begin
            emit_pixel = 1'b1;
          end
        end
      end

      DROP: begin
        if (vs_rise) begin
          state_next = capture_en ? WAIT_FRM : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: byte packing, counters, output strobes and sticky flags.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      hi_byte    <= 8'h00;
      pixel_cnt  <= '0;
      line_count <= '0;
      fifo_write <= 1'b0;
      fifo_data  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      size_err   <= 1'b0;
      fresh      <= 1'b0;
    end else begin
      fifo_write <= emit_pixel;
      frame_done <= frame_end;

      if (emit_pixel) begin
        fifo_data <= pixel;
      end

      if (take_hi) begin
        hi_byte <= d_q;
      end

      if (enter_active || line_end) begin
        phase <= 1'b0;
      end else if (take_hi || emit_pixel || pixel_blocked) begin
        phase <= ~phase;
      end

      if (enter_active || line_end) begin
        pixel_cnt <= '0;
      end else if (emit_pixel) begin
        pixel_cnt <= pixel_cnt_inc;
      end

      if (enter_active) begin
        line_count <= '0;
      end else if (line_end) begin
        line_count <= line_count_inc;
      end

      if (state == IDLE && state_next == WAIT_VS) begin
        fresh <= 1'b1;
      end else if (enter_active) begin
        fresh <= 1'b0;
      end

      if (enter_active && fresh) begin
        overflow <= 1'b0;
      end else if (pixel_blocked) begin
        overflow <= 1'b1;
      end

      if (enter_active && fresh) begin
        size_err <= 1'b0;
      end else if (line_bad || frame_bad) begin
        size_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// ----------------------------------------------------------------------------
// tb_ov7670_capture_writer
// Frame-level bench for ov7670_capture_writer with a small 4x2 geometry.
// A table of frame descriptors drives the camera bus; expected pixels are
// pushed to a scoreboard queue as the low byte of each pixel is driven and
// popped by a monitor whenever the DUT writes. Per-frame write counts,
// frame_done pulses, line_count and sticky flags are checked from the table.
// Build with +define+OV7670_TEST_PATTERN_EN to add the test-pattern frame.
// ----------------------------------------------------------------------------
module tb_ov7670_capture_writer;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int DW = 16;
  localparam int CW = 10;

  logic          clk_write = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          fifo_full;
  logic          fifo_write;
  logic [DW-1:0] fifo_data;
  logic          frame_done;
  logic          overflow;
  logic          size_err;
  logic [CW-1:0] line_count;
`ifdef OV7670_TEST_PATTERN_EN
  logic          test_pattern;
`endif

  ov7670_capture_writer #(
    .DATA_WIDTH (DW),
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .CNT_W      (CW)
  ) dut (
    .clk_write    (clk_write),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
`ifdef OV7670_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data    (fifo_data),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .size_err     (size_err),
    .line_count   (line_count)
  );

  always #5 clk_write = ~clk_write;

  typedef struct {
    string name;
    bit    rstBefore;
    bit    capEn;
    int    enAt;
    int    disAt;
    int    lines;
    int    lineBytes;
    int    oddLine;
    int    fullPixel;
    bit    tp;
    bit    captured;
    int    expWrites;
    int    expDone;
    int    expLineCnt;
    bit    expOvf;
    bit    expSerr;
  } frameVec_t;

  int            assertCount = 0;
  int            failCount   = 0;
  int            writeCnt    = 0;
  int            doneCnt     = 0;
  bit            prevWrite   = 1'b0;
  bit            pendingFull = 1'b0;
  logic [7:0]    byteCtr;
  logic [DW-1:0] sbQ[$];

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one PCLK cycle of camera bus; fifo_full follows the pending request
  task automatic applyStimulus(input bit vs, input bit hr, input logic [7:0] d);
    @(negedge clk_write);
    cam_vsync   = vs;
    cam_href    = hr;
    cam_data    = d;
    fifo_full   = pendingFull;
    pendingFull = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk_write);
    rst_n       = 1'b0;
    capture_en  = 1'b0;
    cam_vsync   = 1'b0;
    cam_href    = 1'b0;
    cam_data    = 8'h00;
    fifo_full   = 1'b0;
    pendingFull = 1'b0;
    repeat (3) @(negedge clk_write);
    rst_n = 1'b1;
  endtask

  // Pop and compare every FIFO write; writes must never be back-to-back
  always @(negedge clk_write) begin
    if (rst_n) begin
      if (fifo_write) begin
        checkOutput("write_spacing", prevWrite, 0);
        writeCnt++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_write", fifo_write, 0);
        end else begin
          checkOutput("fifo_data", fifo_data, sbQ.pop_front());
        end
      end
      if (frame_done) doneCnt++;
      prevWrite = fifo_write;
    end else begin
      prevWrite = 1'b0;
    end
  end

  // One camera frame: blanking, lines with gaps, then blanking again
  task automatic sendFrame(input frameVec_t v);
    int         byteIdx;
    int         pix;
    bit         dropped;
    logic [7:0] hi;
    logic [7:0] d;
    byteIdx = 0;
    pix     = 0;
    dropped = 1'b0;
    hi      = 8'h00;
    byteCtr = 8'h01;
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < v.lines; l++) begin
      int n;
      int pixInLine;
      n         = (l == v.oddLine) ? v.lineBytes - 1 : v.lineBytes;
      pixInLine = 0;
      for (int b = 0; b < n; b++) begin
        d = byteCtr;
        byteCtr++;
        applyStimulus(1'b0, 1'b1, d);
        if (byteIdx == v.enAt)  capture_en = 1'b1;
        if (byteIdx == v.disAt) capture_en = 1'b0;
        if (b % 2 == 0) begin
          hi = d;
        end else begin
          if (v.captured && !dropped) begin
            if (pix == v.fullPixel) begin
              dropped     = 1'b1;
              pendingFull = 1'b1;
            end else if (v.tp) begin
              sbQ.push_back({8'(l), 8'(pixInLine)});
            end else begin
              sbQ.push_back({hi, d});
            end
          end
          pix++;
          pixInLine++;
        end
        byteIdx++;
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    end
    #2;
    if (v.expLineCnt >= 0) begin
      checkOutput({v.name, "_line_count"}, line_count, v.expLineCnt);
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  function automatic frameVec_t mk(input string name, input bit rstBefore, input bit capEn,
                                   input int enAt, input int disAt, input int lines,
                                   input int oddLine, input int fullPixel, input bit tp,
                                   input bit captured, input int expWrites, input int expDone,
                                   input int expLineCnt, input bit expOvf, input bit expSerr);
    frameVec_t v;
    v.name       = name;
    v.rstBefore  = rstBefore;
    v.capEn      = capEn;
    v.enAt       = enAt;
    v.disAt      = disAt;
    v.lines      = lines;
    v.lineBytes  = 2 * FW;
    v.oddLine    = oddLine;
    v.fullPixel  = fullPixel;
    v.tp         = tp;
    v.captured   = captured;
    v.expWrites  = expWrites;
    v.expDone    = expDone;
    v.expLineCnt = expLineCnt;
    v.expOvf     = expOvf;
    v.expSerr    = expSerr;
    return v;
  endfunction

  initial begin
    frameVec_t vecs[$];
    frameVec_t v;
    int        w0;
    int        d0;

    rst_n       = 1'b0;
    capture_en  = 1'b0;
    cam_vsync   = 1'b0;
    cam_href    = 1'b0;
    cam_data    = 8'h00;
    fifo_full   = 1'b0;
`ifdef OV7670_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif

    applyReset();
    @(negedge clk_write);
    #2;
    checkOutput("reset_fifo_write", fifo_write, 0);
    checkOutput("reset_fifo_data",  fifo_data,  0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_overflow",   overflow,   0);
    checkOutput("reset_size_err",   size_err,   0);
    checkOutput("reset_line_count", line_count, 0);

    //              name         rst cap enAt disAt lines odd full tp cap wr  dn lc  ovf serr
    vecs.push_back(mk("basic",     0, 1, -1,  -1,   2,   -1,  -1, 0, 1,  8, 1,  2, 0, 0));
    vecs.push_back(mk("partial",   1, 0,  5,  -1,   2,   -1,  -1, 0, 0,  0, 0, -1, 0, 0));
    vecs.push_back(mk("after_en",  0, 1, -1,  -1,   2,   -1,  -1, 0, 1,  8, 1,  2, 0, 0));
    vecs.push_back(mk("full_p3",   0, 1, -1,  -1,   2,   -1,   3, 0, 1,  3, 0, -1, 1, 0));
    vecs.push_back(mk("after_ovf", 0, 1, -1,  -1,   2,   -1,  -1, 0, 1,  8, 1,  2, 1, 0));
    vecs.push_back(mk("odd_line",  0, 1, -1,  -1,   2,    0,  -1, 0, 1,  7, 1,  2, 1, 1));
    vecs.push_back(mk("disable",   0, 1, -1,   0,   2,   -1,  -1, 0, 1,  8, 1,  2, 1, 1));
    vecs.push_back(mk("fresh",     0, 1, -1,  -1,   2,   -1,  -1, 0, 1,  8, 1,  2, 0, 0));
    vecs.push_back(mk("3lines",    0, 1, -1,  -1,   3,   -1,  -1, 0, 1, 12, 1,  3, 0, 1));
`ifdef OV7670_TEST_PATTERN_EN
    vecs.push_back(mk("pattern",   0, 1, -1,  -1,   2,   -1,  -1, 1, 1,  8, 1,  2, 0, 1));
`endif

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.rstBefore) applyReset();
      capture_en = v.capEn;
`ifdef OV7670_TEST_PATTERN_EN
      test_pattern = v.tp;
`endif
      w0 = writeCnt;
      d0 = doneCnt;
      sendFrame(v);
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
      #2;
      checkOutput({v.name, "_writes"},     writeCnt - w0, v.expWrites);
      checkOutput({v.name, "_frame_done"}, doneCnt - d0,  v.expDone);
      checkOutput({v.name, "_overflow"},   overflow,      v.expOvf);
      checkOutput({v.name, "_size_err"},   size_err,      v.expSerr);
    end

    // Reset in the middle of an active line returns every output to zero
    capture_en = 1'b1;
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'h55);
    @(negedge clk_write);
    rst_n = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("midreset_size_err",   size_err,   0);
    checkOutput("midreset_line_count", line_count, 0);
    checkOutput("midreset_fifo_write", fifo_write, 0);
    repeat (2) @(negedge clk_write);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_write);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_writer.md
Name: ov7670_capture_writer

Overview:
Producer side of the camera-to-frame-buffer pixel FIFO. It runs in the camera PCLK domain (clk_write) and samples OV7670 VSYNC, HREF and D[7:0]. It packs byte pairs into RGB565 pixels and drives the FIFO write port, respecting full. It also reports frame completion, overflow and frame-geometry errors to the read-side control logic.

Parameters:
DATA_WIDTH, 16, pixel width written to FIFO (RGB565)
FRAME_W, 640, expected pixels per line
FRAME_H, 480, expected lines per frame
CNT_W, 10, width of pixel/line counters (must hold FRAME_W and FRAME_H)

Ports:
clk_write  in  1  camera PCLK, rising-edge sampling
rst_n  in  1  asynchronous, active-low reset
capture_en  in  1  level, synchronous to clk_write; 1 = capture frames continuously
cam_vsync  in  1  OV7670 VSYNC (high = vertical blanking)
cam_href  in  1  OV7670 HREF (high = valid line bytes)
cam_data  in  8  OV7670 D[7:0]
fifo_full  in  1  FIFO full flag, write-domain synchronous
fifo_write  out  1  one-cycle write strobe
fifo_data  out  DATA_WIDTH  pixel {hi_byte, lo_byte}
frame_done  out  1  one-cycle pulse at end of each captured frame
overflow  out  1  sticky; set when a pixel met fifo_full
size_err  out  1  sticky; set when a completed frame's geometry differs from FRAME_W x FRAME_H
line_count  out  CNT_W  lines completed in current frame

Behaviour:
- Reset: all outputs 0; state IDLE; byte phase 0; counters 0; input registers 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (vs_q, hr_q, d_q). Edge detection uses the registered value and its previous value.
- States:
  - IDLE: when capture_en=1, go to WAIT_VS.
  - WAIT_VS: wait for vs_q=1, then go to WAIT_FRM. This discards any partial frame in progress.
  - WAIT_FRM: on vs_q falling edge, go to ACTIVE, clear pixel_cnt, line_count and byte phase.
  - ACTIVE: capture bytes while hr_q=1.
  - DROP: ignore all data; on vs_q rising edge, go to WAIT_FRM (or IDLE if capture_en=0). No frame_done is issued.
- Byte packing in ACTIVE:
  - Byte phase 0: latch d_q as the high byte, toggle phase.
  - Byte phase 1: form the pixel and toggle phase.
  - If fifo_full=0: fifo_write=1 next cycle with fifo_data={hi,d_q}, and pixel_cnt++ (saturates at all-ones).
  - If fifo_full=1: no write, overflow<=1, state becomes DROP.
- Latency: pin to fifo_write is 2 clk_write edges after the low byte is presented. fifo_write is never high for two consecutive cycles.
- Line end (hr_q falling edge in ACTIVE):
  - line_count++ (saturating).
  - If pixel_cnt != FRAME_W, or byte phase = 1 (odd byte count), size_err<=1.
  - pixel_cnt and phase are cleared. A dangling high byte is discarded.
- Frame end (vs_q rising edge in ACTIVE):
  - frame_done=1 for one cycle.
  - If line_count != FRAME_H, size_err<=1.
  - If a line is still open (hr_q=1), the same line-end rule is applied first.
  - Next state: WAIT_FRM if capture_en=1, else IDLE.
- capture_en deasserted mid-frame: the current frame completes normally, then the block goes to IDLE.
- Sticky flags: overflow and size_err clear only on reset, or at entry to ACTIVE when capture_en=1 on a fresh IDLE exit. They are not cleared between continuous frames.
- Reset mid-frame: immediate return to reset values. The FIFO is reset by the same rst_n.

Optional Feature:
OV7670_TEST_PATTERN_EN
- Defined: adds input port test_pattern (1 bit). When test_pattern=1 in ACTIVE, the block substitutes fifo_data={line_count[7:0], pixel_cnt[7:0]}. Write timing is unchanged and still driven by HREF byte pairs.
- Undefined: the port is absent and data always comes from the camera.

Decomposition:
- Package ov7670_pkg holds:
  - state enum type (IDLE, WAIT_VS, WAIT_FRM, ACTIVE, DROP)
  - RGB565_W=16
  - default FRAME_W/FRAME_H constants
- One sub-module, ov7670_cam_sample. It holds the input registers plus rise/fall detection for vsync/href and outputs d_q, vs_rise, vs_fall, hr_fall.

Test Plan:
1. Reset; capture_en=1; 4x2 frame (FRAME_W=4, FRAME_H=2) with bytes 0x01..0x10 -> 8 writes, 0x0102,0x0304,...,0x0F10; one frame_done; size_err=0.
2. Enable mid-frame (vsync low, href active) -> no writes until after the next vsync high-then-low; the following frame is captured complete.
3. fifo_full=1 at pixel 3 of line 0 -> overflow=1, no further writes this frame, no frame_done; the next frame is captured normally with overflow still 1.
4. Line with 7 bytes -> 3 writes for that line, size_err=1; the following line's first pixel is aligned to the high byte.
5. 3 lines in a FRAME_H=2 frame -> frame_done pulse, size_err=1, line_count=3 before frame-end.
6. With OV7670_TEST_PATTERN_EN defined and test_pattern=1, line 1 pixel 2 -> fifo_data=0x0102.
